// File: rtl/store_responder_if.sv
// Core-to-data-memory store/load bus between the single-cycle core and store_responder.
// Signal names follow the core's own dmem port names.
interface store_responder_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
    modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

// File: rtl/store_responder.sv
// Word-addressed data memory plus a store-monitor FSM that reports run pass/fail/timeout.
//   state   | meaning
//   ST_RUN  | program running, watching stores and counting cycles
//   ST_PASS | valid store to PASS_ADR seen (absorbing until reset)
//   ST_FAIL | bad store or timeout seen (absorbing until reset)
module store_responder #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned PASS_ADR   = 196,
    parameter int unsigned PASS_DATA  = 7,
    parameter bit          CHECK_DATA = 1'b1,
    parameter int unsigned ALLOW_ADR  = 96,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                i_clk,
    input  logic                i_reset,
    store_responder_if.slave    bus,
    output logic                o_done,
    output logic                o_pass,
    output logic                o_fail,
    output logic                o_timed_out,
    output logic [15:0]         o_store_count,
    output logic [31:0]         o_last_adr,
    output logic [31:0]         o_last_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    logic [31:0]   r_mem [DEPTH];
    state_t        r_state;
    logic [CW-1:0] r_cycles;
    logic          r_done;
    logic          r_pass;
    logic          r_fail;
    logic          r_timed_out;
    logic [15:0]   r_store_count;
    logic [31:0]   r_last_adr;
    logic [31:0]   r_last_data;

    logic [29:0]   w_index;
    logic [AW-1:0] w_addr;
    logic          w_aligned;
    logic          w_in_range;
    logic          w_wr_ok;
    logic          w_is_pass_adr;
    logic          w_data_ok;
    logic          w_is_allow;
    logic          w_timeout_hit;

    assign w_index       = bus.DataAdr[31:2];
    assign w_addr        = w_index[AW-1:0];
    assign w_aligned     = (bus.DataAdr[1:0] == 2'b00);
    assign w_in_range    = (w_index < 30'(DEPTH));
    assign w_wr_ok       = bus.MemWrite && w_aligned && w_in_range;
    assign w_is_pass_adr = (bus.DataAdr == 32'(PASS_ADR));
    assign w_data_ok     = !CHECK_DATA || (bus.WriteData == 32'(PASS_DATA));
    assign w_is_allow    = (bus.DataAdr == 32'(ALLOW_ADR));
    assign w_timeout_hit = (r_cycles == CW'(TIMEOUT - 1));

    // Read-during-write sees the old word: the array is only updated on the edge.
    assign bus.ReadData = (w_aligned && w_in_range) ? r_mem[w_addr] : 32'h0;

    // Memory keeps writing through reset and in every FSM state.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[w_addr] <= bus.WriteData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_RUN;
            r_cycles      <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timed_out   <= 1'b0;
            r_store_count <= '0;
            r_last_adr    <= '0;
            r_last_data   <= '0;
        end else begin
            if (bus.MemWrite) begin
                r_last_adr  <= bus.DataAdr;
                r_last_data <= bus.WriteData;
            end
            case (r_state)
                ST_RUN: begin
                    r_cycles <= r_cycles + 1'b1;
                    if (bus.MemWrite && r_store_count != 16'hFFFF) begin
                        r_store_count <= r_store_count + 16'd1;
                    end
                    // A store decision takes priority over a coincident timeout.
                    if (bus.MemWrite && !w_aligned) begin
                        r_state <= ST_FAIL;
                        r_fail  <= 1'b1;
                        r_done  <= 1'b1;
                    end else if (bus.MemWrite && w_is_pass_adr && w_data_ok) begin
                        r_state <= ST_PASS;
                        r_pass  <= 1'b1;
                        r_done  <= 1'b1;
                    end else if (bus.MemWrite && (w_is_pass_adr || !w_is_allow)) begin
                        r_state <= ST_FAIL;
                        r_fail  <= 1'b1;
                        r_done  <= 1'b1;
                    end else if (w_timeout_hit) begin
                        r_state     <= ST_FAIL;
                        r_fail      <= 1'b1;
                        r_done      <= 1'b1;
                        r_timed_out <= 1'b1;
                    end
                end
                ST_PASS: r_state <= ST_PASS;
                ST_FAIL: r_state <= ST_FAIL;
                default: begin
                    r_state <= ST_FAIL;
                    r_fail  <= 1'b1;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    assign o_done        = r_done;
    assign o_pass        = r_pass;
    assign o_fail        = r_fail;
    assign o_timed_out   = r_timed_out;
    assign o_store_count = r_store_count;
    assign o_last_adr    = r_last_adr;
    assign o_last_data   = r_last_data;

endmodule
